// File: rtl/cpu_defs.sv
// Shared definitions for the instruction-fetch refill path: FSM encoding and
// word/byte geometry of the byte-wide RAM port.
package cpu_defs;

  localparam int ADDR_WIDTH_DEF = 32;
  localparam int WORD_BYTES     = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    READ = 2'd2,
    LAST = 2'd3
  } state_t;

endpackage

// File: rtl/icache_refill.sv
// I-cache miss refill engine: fetches a little-endian word byte by byte from
// the shared RAM port and hands it back to the i-cache as a one-cycle pulse.
module icache_refill
  import cpu_defs::*;
#(
  parameter int ADDR_WIDTH = cpu_defs::ADDR_WIDTH_DEF,
  parameter int WORD_BYTES = cpu_defs::WORD_BYTES
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic [BYTE_W-1:0]     mem_din,
  output logic                  refill_valid,
  output logic [ADDR_WIDTH-1:0] refill_addr,
  output logic [31:0]           refill_data,
  output logic                  busy
);

  localparam int CNT_W  = $clog2(WORD_BYTES);
  localparam int WORD_W = WORD_BYTES * BYTE_W;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [WORD_W-1:0]       word_reg, word_next, word_cap;
  logic [ADDR_WIDTH-1:0]   base_reg, base_next;
  logic                    refill_valid_reg, refill_valid_next;
  logic [ADDR_WIDTH-1:0]   refill_addr_reg, refill_addr_next;
  logic [WORD_W-1:0]       refill_data_reg, refill_data_next;
  logic [WORD_BYTES-1:0]   byte_we;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[1:0];

  // RAM data lags the address by one cycle, so READ with cnt=k+1 captures byte k.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_byte
      if (gi == WORD_BYTES - 1) begin : g_last
        assign byte_we[gi] = (state_reg == LAST);
      end else begin : g_mid
        assign byte_we[gi] = (state_reg == READ) && (cnt_reg == CNT_W'(gi + 1));
      end
      assign word_cap[gi*BYTE_W +: BYTE_W] =
        byte_we[gi] ? mem_din : word_reg[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      word_reg         <= '0;
      base_reg         <= '0;
      refill_valid_reg <= 1'b0;
      refill_addr_reg  <= '0;
      refill_data_reg  <= '0;
    end else if (rdy_in) begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      word_reg         <= word_next;
      base_reg         <= base_next;
      refill_valid_reg <= refill_valid_next;
      refill_addr_reg  <= refill_addr_next;
      refill_data_reg  <= refill_data_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    word_next         = word_cap;
    base_next         = base_reg;
    refill_valid_next = 1'b0;
    refill_addr_next  = refill_addr_reg;
    refill_data_next  = refill_data_reg;
    miss_ready        = 1'b0;
    mem_req           = 1'b0;
    mem_a             = '0;

    unique case (state_reg)
      IDLE: begin
        miss_ready = 1'b1;
        if (miss_valid && !flush) begin
          base_next  = {miss_addr[ADDR_WIDTH-1:2], 2'b00};
          state_next = REQ;
        end
      end
      REQ: begin
        mem_req = 1'b1;
        mem_a   = base_reg;
        if (mem_gnt) begin
          state_next = READ;
          cnt_next   = '0;
        end
      end
      READ: begin
        mem_req  = 1'b1;
        mem_a    = base_reg + ADDR_WIDTH'(cnt_reg);
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WORD_BYTES - 1)) state_next = LAST;
      end
      LAST: begin
        mem_req           = 1'b1;
        mem_a             = base_reg + ADDR_WIDTH'(WORD_BYTES - 1);
        refill_valid_next = 1'b1;
        refill_data_next  = word_cap;
        refill_addr_next  = base_reg;
        word_next         = '0;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A redirect kills the fetch outright, including a refill about to be posted.
    if (flush) begin
      state_next        = IDLE;
      cnt_next          = '0;
      word_next         = '0;
      refill_valid_next = 1'b0;
      refill_addr_next  = refill_addr_reg;
      refill_data_next  = refill_data_reg;
    end
  end

  assign mem_wr       = 1'b0;
  assign busy         = (state_reg != IDLE);
  assign refill_valid = refill_valid_reg;
  assign refill_addr  = refill_addr_reg;
  assign refill_data  = refill_data_reg;

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: fixed-latency refills against a small
// byte RAM model, with stalls, grant delay, flush and back-to-back misses.
module tb_icache_refill;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req;
  logic        mem_gnt;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        refill_valid;
  logic [31:0] refill_addr;
  logic [31:0] refill_data;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ram [0:8191];
  logic       prev_req = 1'b0;
  logic       prev_gnt = 1'b0;

  always #5 clk_in = ~clk_in;

  icache_refill dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .flush        (flush),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_a        (mem_a),
    .mem_wr       (mem_wr),
    .mem_din      (mem_din),
    .refill_valid (refill_valid),
    .refill_addr  (refill_addr),
    .refill_data  (refill_data),
    .busy         (busy)
  );

  // RAM read port shares the global ready, so a stall holds mem_din too.
  always @(posedge clk_in) begin
    if (rdy_in) mem_din <= ram[mem_a[12:0]];
  end

  // Once granted, the arbiter must keep the grant while the request stays up.
  always @(posedge clk_in) begin
    if (!rst_in && prev_req && prev_gnt && mem_req)
      assert (mem_gnt) else $error("arbiter dropped grant mid-refill");
    prev_req <= mem_req;
    prev_gnt <= mem_gnt;
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset;
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; miss_valid = 1'b0;
    miss_addr = '0; mem_gnt = 1'b0;
    tick();
    vectors++; if (refill_valid !== 1'b0) begin miscompares++; $display("FAIL reset_refill_valid got %b want 0", refill_valid); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL reset_miss_ready got %b want 1", miss_ready); end
    vectors++; if (mem_a !== 32'h0) begin miscompares++; $display("FAIL reset_mem_a got %h want 0", mem_a); end
    vectors++; if (refill_data !== 32'h0 || refill_addr !== 32'h0) begin miscompares++; $display("FAIL reset_refill_regs got %h/%h want 0/0", refill_data, refill_addr); end
    tick();
    rst_in = 1'b0;
    miss_valid = 1'b1; miss_addr = 32'h1000; mem_gnt = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    tick();
    vectors++; if (mem_req !== 1'b1 || mem_a !== 32'h1001) begin miscompares++; $display("FAIL reset_pre_read got req=%b a=%h want 1/00001001", mem_req, mem_a); end
    #3 rst_in = 1'b1;
    #1;
    vectors++; if (mem_req !== 1'b0 || busy !== 1'b0 || refill_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset got req=%b busy=%b rv=%b want 0/0/0", mem_req, busy, refill_valid); end
    vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL async_reset_miss_ready got %b want 1", miss_ready); end
    tick();
    rst_in = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b want 0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    miss_valid = 1'b1; miss_addr = 32'h1002; mem_gnt = 1'b1;
    tick();
    miss_valid = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_a !== 32'h1000) begin miscompares++; $display("FAIL basic_req got req=%b a=%h want 1/00001000", mem_req, mem_a); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (mem_a !== 32'h1000 + k) begin miscompares++; $display("FAIL basic_addr%0d got %h want %h", k, mem_a, 32'h1000 + k); end
    end
    tick();
    vectors++; if (refill_valid !== 1'b0 || mem_a !== 32'h1003) begin miscompares++; $display("FAIL basic_last got rv=%b a=%h want 0/00001003", refill_valid, mem_a); end
    tick();
    vectors++; if (refill_valid !== 1'b1 || refill_data !== 32'h00500513 || refill_addr !== 32'h1000) begin miscompares++; $display("FAIL basic_refill got rv=%b d=%h a=%h want 1/00500513/00001000", refill_valid, refill_data, refill_addr); end
    vectors++; if (busy !== 1'b0 || miss_ready !== 1'b1) begin miscompares++; $display("FAIL basic_idle got busy=%b mr=%b want 0/1", busy, miss_ready); end
    tick();
    vectors++; if (refill_valid !== 1'b0 || refill_data !== 32'h00500513) begin miscompares++; $display("FAIL basic_pulse got rv=%b d=%h want 0/00500513", refill_valid, refill_data); end
    $display("test_basic done");
  endtask

  task automatic test_grant_delay;
    mem_gnt = 1'b0; miss_valid = 1'b1; miss_addr = 32'h0800;
    tick();
    miss_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (mem_req !== 1'b1 || mem_a !== 32'h0800) begin miscompares++; $display("FAIL gnt_wait%0d got req=%b a=%h want 1/00000800", c, mem_req, mem_a); end
      tick();
    end
    mem_gnt = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    vectors++; if (refill_valid !== 1'b1 || refill_data !== 32'hefbeadde || refill_addr !== 32'h0800) begin miscompares++; $display("FAIL gnt_refill got rv=%b d=%h a=%h want 1/efbeadde/00000800", refill_valid, refill_data, refill_addr); end
    $display("test_grant_delay done");
  endtask

  task automatic test_rdy_stall;
    miss_valid = 1'b1; miss_addr = 32'h1000; mem_gnt = 1'b1;
    tick();
    miss_valid = 1'b0;
    tick();
    tick();
    vectors++; if (mem_a !== 32'h1001) begin miscompares++; $display("FAIL stall_start got %h want 00001001", mem_a); end
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++; if (mem_a !== 32'h1001) begin miscompares++; $display("FAIL stall_hold%0d got %h want 00001001", c, mem_a); end
    end
    rdy_in = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    vectors++; if (refill_valid !== 1'b0) begin miscompares++; $display("FAIL stall_early got rv=%b want 0", refill_valid); end
    tick();
    vectors++; if (refill_valid !== 1'b1 || refill_data !== 32'h00500513 || refill_addr !== 32'h1000) begin miscompares++; $display("FAIL stall_refill got rv=%b d=%h a=%h want 1/00500513/00001000", refill_valid, refill_data, refill_addr); end
    $display("test_rdy_stall done");
  endtask

  task automatic test_flush;
    miss_valid = 1'b1; miss_addr = 32'h0800; mem_gnt = 1'b1;
    tick();
    miss_valid = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++; if (refill_valid !== 1'b0) begin miscompares++; $display("FAIL flush_last_rv got %b want 0", refill_valid); end
    vectors++; if (busy !== 1'b0 || miss_ready !== 1'b1 || mem_req !== 1'b0) begin miscompares++; $display("FAIL flush_last_idle got busy=%b mr=%b req=%b want 0/1/0", busy, miss_ready, mem_req); end
    vectors++; if (refill_data !== 32'h00500513) begin miscompares++; $display("FAIL flush_data_kept got %h want 00500513", refill_data); end
    flush = 1'b1; miss_valid = 1'b1; miss_addr = 32'h1000;
    tick();
    flush = 1'b0; miss_valid = 1'b0;
    vectors++; if (busy !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL flush_idle_miss got busy=%b req=%b want 0/0", busy, mem_req); end
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL flush_idle_after got busy=%b want 0", busy); end
    $display("test_flush done");
  endtask

  task automatic test_wrap;
    miss_valid = 1'b1; miss_addr = 32'hffffffff; mem_gnt = 1'b1;
    tick();
    miss_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    vectors++; if (mem_a !== 32'hffffffff) begin miscompares++; $display("FAIL wrap_addr got %h want ffffffff", mem_a); end
    tick();
    tick();
    vectors++; if (refill_valid !== 1'b1 || refill_data !== 32'h04030201 || refill_addr !== 32'hfffffffc) begin miscompares++; $display("FAIL wrap_refill got rv=%b d=%h a=%h want 1/04030201/fffffffc", refill_valid, refill_data, refill_addr); end
    $display("test_wrap done");
  endtask

  task automatic test_back_to_back;
    int n = 0;
    logic chk_busy = 1'b0;
    logic wr_bad = 1'b0;
    miss_valid = 1'b1; miss_addr = 32'h0; mem_gnt = 1'b1;
    tick();
    miss_addr = 32'h4;
    for (int c = 0; c < 30 && n < 2; c++) begin
      tick();
      if (mem_wr !== 1'b0) wr_bad = 1'b1;
      if (chk_busy) begin
        chk_busy = 1'b0;
        miss_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
      end
      if (refill_valid === 1'b1) begin
        if (n == 0) begin
          vectors++; if (c != 5 || refill_data !== 32'h44332211 || refill_addr !== 32'h0) begin miscompares++; $display("FAIL b2b_first got cyc=%0d d=%h a=%h want 5/44332211/00000000", c, refill_data, refill_addr); end
          vectors++; if (miss_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", miss_ready); end
          chk_busy = 1'b1;
        end else begin
          vectors++; if (c != 12 || refill_data !== 32'h88776655 || refill_addr !== 32'h4) begin miscompares++; $display("FAIL b2b_second got cyc=%0d d=%h a=%h want 12/88776655/00000004", c, refill_data, refill_addr); end
        end
        n++;
      end
    end
    miss_valid = 1'b0;
    vectors++; if (n != 2) begin miscompares++; $display("FAIL b2b_count got %0d refills want 2", n); end
    vectors++; if (wr_bad !== 1'b0) begin miscompares++; $display("FAIL b2b_mem_wr got nonzero want 0"); end
    $display("test_back_to_back done");
  endtask

  initial begin
    ram[13'h1000] = 8'h13; ram[13'h1001] = 8'h05; ram[13'h1002] = 8'h50; ram[13'h1003] = 8'h00;
    ram[13'h0800] = 8'hde; ram[13'h0801] = 8'had; ram[13'h0802] = 8'hbe; ram[13'h0803] = 8'hef;
    ram[13'h1ffc] = 8'h01; ram[13'h1ffd] = 8'h02; ram[13'h1ffe] = 8'h03; ram[13'h1fff] = 8'h04;
    ram[13'h0000] = 8'h11; ram[13'h0001] = 8'h22; ram[13'h0002] = 8'h33; ram[13'h0003] = 8'h44;
    ram[13'h0004] = 8'h55; ram[13'h0005] = 8'h66; ram[13'h0006] = 8'h77; ram[13'h0007] = 8'h88;
    test_reset();
    test_basic();
    test_grant_delay();
    test_rdy_stall();
    test_flush();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
